// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: T-state tracking, opcode decode,
// latched ALU flags, run/single-step gating, sticky halt and retired-instruction count.
module microcode_sequencer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic [3:0]           instruction,
  input  logic                 carry_in,
  input  logic                 zero_in,
  output logic [14:0]          ctrlwrd,
  output logic                 fi,
  output logic [2:0]           stage,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } stage_t;

  localparam logic [14:0] HLT = 15'h4000;
  localparam logic [14:0] MI  = 15'h2000;
  localparam logic [14:0] RI  = 15'h1000;
  localparam logic [14:0] RO  = 15'h0800;
  localparam logic [14:0] IO  = 15'h0400;
  localparam logic [14:0] II  = 15'h0200;
  localparam logic [14:0] AI  = 15'h0100;
  localparam logic [14:0] AO  = 15'h0080;
  localparam logic [14:0] SO  = 15'h0040;
  localparam logic [14:0] SU  = 15'h0020;
  localparam logic [14:0] BI  = 15'h0010;
  localparam logic [14:0] OI  = 15'h0008;
  localparam logic [14:0] CE  = 15'h0004;
  localparam logic [14:0] CO  = 15'h0002;
  localparam logic [14:0] J   = 15'h0001;

  localparam logic [3:0] OP_HLT = 4'hF;

  stage_t                 stage_reg;
  logic                   step_q_reg;
  logic                   carry_reg;
  logic                   zero_reg;
  logic                   halted_reg;
  logic [CNT_WIDTH-1:0]   count_reg;

  stage_t                 last_stage;
  logic [14:0]            word;
  logic                   fi_w;
  logic                   advance;

  always_comb begin
    case (instruction)
      4'h1, 4'h4:                         last_stage = T3;
      4'h2, 4'h3:                         last_stage = T4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF: last_stage = T2;
      default:                            last_stage = T1;
    endcase
  end

  // Decode is gated by rst so the bus is quiet for the whole reset pulse.
  always_comb begin
    word = '0;
    fi_w = 1'b0;
    if (!rst) begin
      if (halted_reg) begin
        word = HLT;
      end else begin
        case (stage_reg)
          T0: word = MI | CO;
          T1: word = RO | II | CE;
          T2: begin
            case (instruction)
              4'h1, 4'h2, 4'h3, 4'h4: word = MI | IO;
              4'h5:                   word = AO | OI;
              4'h6:                   word = IO | J;
              4'h7:                   word = IO | AI;
              4'h8:                   word = carry_reg ? (IO | J) : '0;
              4'h9:                   word = zero_reg  ? (IO | J) : '0;
              OP_HLT:                 word = HLT;
              default:                word = '0;
            endcase
          end
          T3: begin
            case (instruction)
              4'h1:       word = RO | AI;
              4'h2, 4'h3: word = RO | BI;
              4'h4:       word = AO | RI;
              default:    word = '0;
            endcase
          end
          T4: begin
            if (instruction == 4'h2) begin
              word = SO | AI;
              fi_w = 1'b1;
            end else if (instruction == 4'h3) begin
              word = SO | AI | SU;
              fi_w = 1'b1;
            end
          end
          default: word = '0;
        endcase
      end
    end
  end

  assign advance = ~halted_reg & (run | (step & ~step_q_reg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg  <= T0;
      step_q_reg <= 1'b0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      halted_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      step_q_reg <= step;
      if (advance) begin
        if (fi_w) begin
          carry_reg <= carry_in;
          zero_reg  <= zero_in;
        end
        // HLT parks in T2 and is never counted as retired.
        if (instruction == OP_HLT && stage_reg == T2) begin
          halted_reg <= 1'b1;
        end else if (stage_reg == last_stage) begin
          stage_reg <= T0;
          count_reg <= count_reg + 1'b1;
        end else begin
          stage_reg <= stage_t'(stage_reg + 3'd1);
        end
      end
    end
  end

  assign ctrlwrd     = word;
  assign fi          = fi_w;
  assign stage       = stage_reg;
  assign carry_flag  = carry_reg;
  assign zero_flag   = zero_reg;
  assign halted      = halted_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios followed by random
// stimulus, all checked against a microprogram-table reference model.
module tb_microcode_sequencer;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, run, step, carry_in, zero_in;
  logic [3:0]    instruction;
  logic [14:0]   ctrlwrd;
  logic          fi;
  logic [2:0]    stage;
  logic          carry_flag, zero_flag, halted;
  logic [CW-1:0] instr_count;

  microcode_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .instruction(instruction),
    .carry_in(carry_in), .zero_in(zero_in), .ctrlwrd(ctrlwrd), .fi(fi),
    .stage(stage), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: per-opcode microprogram listing plus instruction length.
  logic [14:0] prog [16][5];
  int          len_of [16];
  int          m_idx, m_cnt;
  bit          m_halt, m_c, m_z, m_stepq;

  task automatic build_prog();
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 5; t++) prog[op][t] = 15'h0000;
      prog[op][0] = 15'h2002;
      prog[op][1] = 15'h0A04;
      len_of[op]  = 2;
    end
    prog[1][2] = 15'h2400; prog[1][3] = 15'h0900; len_of[1] = 4;
    prog[2][2] = 15'h2400; prog[2][3] = 15'h0910; prog[2][4] = 15'h0140; len_of[2] = 5;
    prog[2][3] = 15'h0810;
    prog[3][2] = 15'h2400; prog[3][3] = 15'h0810; prog[3][4] = 15'h0160; len_of[3] = 5;
    prog[4][2] = 15'h2400; prog[4][3] = 15'h1080; len_of[4] = 4;
    prog[5][2] = 15'h0088; len_of[5] = 3;
    prog[6][2] = 15'h0401; len_of[6] = 3;
    prog[7][2] = 15'h0500; len_of[7] = 3;
    prog[8][2] = 15'h0401; len_of[8] = 3;
    prog[9][2] = 15'h0401; len_of[9] = 3;
    prog[15][2] = 15'h4000; len_of[15] = 3;
  endtask

  function automatic logic [14:0] exp_word();
    logic [14:0] w;
    if (rst) return 15'h0000;
    if (m_halt) return 15'h4000;
    w = prog[instruction][m_idx];
    if (m_idx == 2 && instruction == 4'h8 && !m_c) w = 15'h0000;
    if (m_idx == 2 && instruction == 4'h9 && !m_z) w = 15'h0000;
    return w;
  endfunction

  function automatic bit exp_fi();
    return !rst && !m_halt && m_idx == 4 && (instruction == 4'h2 || instruction == 4'h3);
  endfunction

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_halt = 0; m_c = 0; m_z = 0; m_stepq = 0;
  endtask

  task automatic model_edge();
    bit adv;
    if (rst) begin
      model_reset();
      return;
    end
    adv = !m_halt && (run || (step && !m_stepq));
    m_stepq = step;
    if (adv) begin
      if (exp_fi()) begin
        m_c = carry_in;
        m_z = zero_in;
      end
      if (instruction == 4'hF && m_idx == 2) m_halt = 1;
      else if (m_idx == len_of[instruction] - 1) begin
        m_idx = 0;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end else m_idx++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("ctrlwrd", 32'(ctrlwrd), 32'(exp_word()));
    chk("fi", 32'(fi), 32'(exp_fi()));
    chk("stage", 32'(stage), 32'(m_idx));
    chk("carry_flag", 32'(carry_flag), 32'(m_c));
    chk("zero_flag", 32'(zero_flag), 32'(m_z));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
  endtask

  // One clock: model follows the rising edge, outputs are checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_ctrlwrd", 32'(ctrlwrd), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    check_all();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_word", 32'(ctrlwrd), 32'h2002);
    check_all();
  endtask

  int saved_cnt;
  int halt_cycles;
  logic [3:0] op;

  initial begin
    build_prog();
    rst = 1'b1; run = 1'b0; step = 1'b0; instruction = 4'h0;
    carry_in = 1'b0; zero_in = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // LDA in free-run
    instruction = 4'h1; run = 1'b1;
    tick(); chk("lda_t1", 32'(ctrlwrd), 32'h0A04);
    tick(); chk("lda_t2", 32'(ctrlwrd), 32'h2400);
    tick(); chk("lda_t3", 32'(ctrlwrd), 32'h0900);
    tick(); chk("lda_t0", 32'(ctrlwrd), 32'h2002);
    chk("lda_count", 32'(instr_count), 32'h1);

    // SUB with carry/zero set, then JC and JZ taken
    instruction = 4'h3; carry_in = 1'b1; zero_in = 1'b1;
    repeat (4) tick();
    chk("sub_t4", 32'(ctrlwrd), 32'h0160);
    chk("sub_fi", 32'(fi), 32'h1);
    tick();
    chk("sub_carry", 32'(carry_flag), 32'h1);
    chk("sub_zero", 32'(zero_flag), 32'h1);
    carry_in = 1'b0; zero_in = 1'b0;
    instruction = 4'h8;
    repeat (2) tick(); chk("jc_taken", 32'(ctrlwrd), 32'h0401);
    tick();
    instruction = 4'h9;
    repeat (2) tick(); chk("jz_taken", 32'(ctrlwrd), 32'h0401);
    tick();

    // ADD clears flags, JC not taken but still retires
    instruction = 4'h2;
    repeat (5) tick();
    chk("add_carry_clr", 32'(carry_flag), 32'h0);
    instruction = 4'h8;
    saved_cnt = m_cnt;
    repeat (2) tick(); chk("jc_not_taken", 32'(ctrlwrd), 32'h0);
    tick();
    chk("jc_retired", 32'(instr_count), 32'((saved_cnt + 1) % 256));

    // Single-step: held level advances once, then separate pulses
    instruction = 4'h1; run = 1'b0; step = 1'b1;
    repeat (5) tick();
    chk("step_held", 32'(stage), 32'h1);
    repeat (2) begin
      step = 1'b0; tick();
      step = 1'b1; tick();
    end
    chk("step_pulses", 32'(stage), 32'h3);
    step = 1'b0; run = 1'b1;
    tick();

    // HLT: sticky across run and step activity
    instruction = 4'hF;
    repeat (2) tick();
    chk("hlt_t2", 32'(ctrlwrd), 32'h4000);
    saved_cnt = m_cnt;
    tick();
    chk("halted_set", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step = i[0];
      tick();
    end
    chk("halt_word", 32'(ctrlwrd), 32'h4000);
    chk("halt_count", 32'(instr_count), 32'(saved_cnt));
    step = 1'b0;
    do_reset();
    chk("halt_cleared", 32'(halted), 32'h0);

    // Counter wrap over 256 NOPs
    instruction = 4'h0;
    repeat (512) tick();
    chk("count_wrap", 32'(instr_count), 32'h0);

    // Async reset in the middle of ADD T3
    instruction = 4'h2;
    repeat (3) tick();
    chk("add_t3", 32'(ctrlwrd), 32'h0810);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_word", 32'(ctrlwrd), 32'h0);
    chk("mid_rst_count", 32'(instr_count), 32'h0);
    chk("mid_rst_stage", 32'(stage), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // Random traffic
    halt_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!m_halt && m_idx == 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h2;
        instruction = op;
      end
      run      = ($urandom_range(0, 3) != 0);
      step     = 1'($urandom_range(0, 1));
      carry_in = 1'($urandom_range(0, 1));
      zero_in  = 1'($urandom_range(0, 1));
      tick();
      if (m_halt) begin
        halt_cycles++;
        if (halt_cycles > 8) begin
          halt_cycles = 0;
          do_reset();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
